// File: rtl/msg_fifo_arbiter_pkg.sv
// ----------------------------------------------------------------------------
// parser_defs
// Shared types for the parser lanes, the message FIFO and the arbiter that
// sits between them.
//   parsed_msg_t     : one parsed message as produced by parser_fsm
//   MAX_PARSER_LANES : upper bound on the number of parser lanes
//   arb_stat_t       : 16-bit statistics counter type
//   stat_sat_inc     : saturating increment for arb_stat_t counters
// ----------------------------------------------------------------------------
package parser_defs;

   localparam int MAX_PARSER_LANES = 8;

   typedef struct packed {
      logic [7:0]  msg_type;
      logic [15:0] msg_len;
      logic [31:0] payload;
   } parsed_msg_t;

   typedef logic [15:0] arb_stat_t;

   localparam arb_stat_t ARB_STAT_MAX = 16'hFFFF;

   // Counters stick at all-ones rather than wrapping back to zero.
   function automatic arb_stat_t stat_sat_inc(input arb_stat_t v);
      return (v == ARB_STAT_MAX) ? v : v + 16'd1;
   endfunction

endpackage

// File: rtl/msg_fifo_arbiter_rr_arbiter.sv
// ----------------------------------------------------------------------------
// rr_arbiter
// Purely combinational round-robin arbiter. Search starts at ptr and wraps
// modulo NUM_SRC; the first requesting index wins.
// Ports:
//   req     in  NUM_SRC  request vector
//   ptr     in  SRC_W    highest-priority index (must be < NUM_SRC)
//   gnt     out NUM_SRC  one-hot grant (zero when no request)
//   gnt_idx out SRC_W    index of the granted request (0 when none)
//   any_gnt out 1        at least one request present
// ----------------------------------------------------------------------------
module rr_arbiter #(
   parameter  int NUM_SRC = 4,
   localparam int SRC_W   = $clog2(NUM_SRC)
) (
   input  logic [NUM_SRC-1:0] req,
   input  logic [SRC_W-1:0]   ptr,
   output logic [NUM_SRC-1:0] gnt,
   output logic [SRC_W-1:0]   gnt_idx,
   output logic               any_gnt
);

   // One spare bit so ptr + k cannot overflow before the modulo wrap.
   logic [SRC_W:0]   cand;
   logic [SRC_W-1:0] idx;

   always_comb begin
      gnt     = '0;
      gnt_idx = '0;
      any_gnt = 1'b0;
      cand    = '0;
      idx     = '0;
      for (int k = 0; k < NUM_SRC; k++) begin
         cand = {1'b0, ptr} + (SRC_W+1)'(k);
         if (cand >= (SRC_W+1)'(NUM_SRC)) begin
            cand = cand - (SRC_W+1)'(NUM_SRC);
         end
         idx = cand[SRC_W-1:0];
         if (!any_gnt && req[idx]) begin
            gnt[idx] = 1'b1;
            gnt_idx  = idx;
            any_gnt  = 1'b1;
         end
      end
   end

endmodule

// File: rtl/msg_fifo_arbiter.sv
// ----------------------------------------------------------------------------
// msg_fifo_arbiter
// Lets NUM_SRC parser lanes share the single write port of msg_fifo. One lane
// is granted per cycle (round robin) into a one-entry output register, which
// then drives the FIFO write port while respecting fifo_full. An accepted
// message is never dropped (except by reset).
//
// Optional statistics are compiled in with the macro MSG_ARB_STATS_EN; without
// it grant_count and stall_cycles are constant zero and no counters exist.
//
// Ports:
//   clk            in  1                  clock
//   reset          in  1                  asynchronous, active-high reset
//   src_valid      in  NUM_SRC            lane i presents src_msg[i]
//   src_msg        in  NUM_SRC x msg      per-lane message
//   src_ready      out NUM_SRC            lane i accepted this cycle (one-hot/0)
//   fifo_full      in  1                  msg_fifo full flag
//   fifo_write_en  out 1                  msg_fifo write strobe
//   fifo_msg       out parsed_msg_t       message to msg_fifo
//   fifo_src_id    out SRC_W              lane that produced fifo_msg
//   grant_count    out NUM_SRC x 16       per-lane accept counters (saturating)
//   stall_cycles   out 16                 cycles held off by fifo_full
// ----------------------------------------------------------------------------
module msg_fifo_arbiter
   import parser_defs::*;
#(
   parameter  int NUM_SRC = 4,
   localparam int SRC_W   = $clog2(NUM_SRC)
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic        [NUM_SRC-1:0]    src_valid,
   input  parsed_msg_t [NUM_SRC-1:0]    src_msg,
   output logic        [NUM_SRC-1:0]    src_ready,
   input  logic                         fifo_full,
   output logic                         fifo_write_en,
   output parsed_msg_t                  fifo_msg,
   output logic        [SRC_W-1:0]      fifo_src_id,
   output arb_stat_t   [NUM_SRC-1:0]    grant_count,
   output arb_stat_t                    stall_cycles
);

   // Output stage and round-robin state
   logic             out_valid;
   parsed_msg_t      out_msg;
   logic [SRC_W-1:0] out_src;
   logic [SRC_W-1:0] rr_ptr;

   // Arbitration results
   logic [NUM_SRC-1:0] gnt;
   logic [SRC_W-1:0]   gnt_idx;
   logic               any_gnt;
   logic               load_ok;
   logic               accept;

   // Pointer moves to the lane just after the winner, wrapping at NUM_SRC-1.
   function automatic logic [SRC_W-1:0] next_ptr(input logic [SRC_W-1:0] g);
      return (g == SRC_W'(NUM_SRC-1)) ? '0 : g + SRC_W'(1);
   endfunction

   rr_arbiter #(
      .NUM_SRC (NUM_SRC)
   ) u_rr_arbiter (
      .req     (src_valid),
      .ptr     (rr_ptr),
      .gnt     (gnt),
      .gnt_idx (gnt_idx),
      .any_gnt (any_gnt)
   );

   // The output register may be reloaded when it is empty or is being
   // written to the FIFO in this same cycle, giving one message per cycle.
   assign fifo_write_en = out_valid && !fifo_full;
   assign load_ok       = !out_valid || fifo_write_en;
   assign src_ready     = load_ok ? gnt : '0;
   assign accept        = load_ok && any_gnt;

   assign fifo_msg      = out_msg;
   assign fifo_src_id   = out_src;

   // ---- output stage register ----
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         out_valid <= 1'b0;
         out_msg   <= '0;
         out_src   <= '0;
         rr_ptr    <= '0;
      end else if (accept) begin
         out_valid <= 1'b1;
         out_msg   <= src_msg[gnt_idx];
         out_src   <= gnt_idx;
         rr_ptr    <= next_ptr(gnt_idx);
      end else if (fifo_write_en) begin
         out_valid <= 1'b0;
      end
   end

`ifdef MSG_ARB_STATS_EN
   arb_stat_t [NUM_SRC-1:0] grant_cnt;
   arb_stat_t               stall_cnt;

   // ---- statistics counters ----
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         grant_cnt <= '0;
         stall_cnt <= '0;
      end else begin
         if (accept) begin
            grant_cnt[gnt_idx] <= stat_sat_inc(grant_cnt[gnt_idx]);
         end
         if (out_valid && fifo_full) begin
            stall_cnt <= stat_sat_inc(stall_cnt);
         end
      end
   end

   assign grant_count  = grant_cnt;
   assign stall_cycles = stall_cnt;
`else
   assign grant_count  = '0;
   assign stall_cycles = '0;
`endif

endmodule
